// File: rtl/mainmenu_pkg.sv
// mainmenu_pkg: option codes, FSM state and direction encodings shared by the menu logic and renderer
package mainmenu_pkg;
   typedef logic [2:0] opt_t;
   typedef logic [4:0] btn_t;
   localparam opt_t OPT_PLAY_1P  = 3'd0;
   localparam opt_t OPT_PLAY_END = 3'd1;
   localparam opt_t OPT_PLAY_2P  = 3'd2;
   localparam opt_t OPT_TOP_1P   = 3'd3;
   localparam opt_t OPT_TOP_END  = 3'd4;
   localparam int BTN_SEL   = 4;
   localparam int BTN_UP    = 3;
   localparam int BTN_DOWN  = 2;
   localparam int BTN_LEFT  = 1;
   localparam int BTN_RIGHT = 0;
   typedef enum logic [2:0] {IDLE, WAIT_REL, NAV, LAUNCH, DONE} state_t;
   typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
   function automatic btn_t dir_mask(dir_t d);
      return {1'b0, d == DIR_UP, d == DIR_DOWN, d == DIR_LEFT, d == DIR_RIGHT};
   endfunction
endpackage

// File: rtl/mainmenu_if.sv
// mainmenu_if: button levels in, selected option / launch pulse / mode out
interface mainmenu_if;
   import mainmenu_pkg::*;
   logic menu_active;
   logic btn_up, btn_down, btn_left, btn_right, btn_select;
   opt_t sel;
   logic start;
   opt_t mode;
   modport master(output menu_active, btn_up, btn_down, btn_left, btn_right, btn_select,
                  input sel, start, mode);
   modport slave(input menu_active, btn_up, btn_down, btn_left, btn_right, btn_select,
                 output sel, start, mode);
endinterface

// File: rtl/mainmenu_nav_lut.sv
// mainmenu_nav_lut: saturating two-column grid move for one direction
module mainmenu_nav_lut
   import mainmenu_pkg::*;
(
   input  opt_t sel_i,
   input  dir_t dir_i,
   output opt_t next_sel_o
);
   opt_t up, down, left, right;
   always_comb begin
      up    = sel_i == OPT_PLAY_END ? OPT_PLAY_1P : sel_i == OPT_PLAY_2P ? OPT_PLAY_END :
              sel_i == OPT_TOP_END ? OPT_TOP_1P : sel_i;
      down  = sel_i == OPT_PLAY_1P ? OPT_PLAY_END : sel_i == OPT_PLAY_END ? OPT_PLAY_2P :
              sel_i == OPT_TOP_1P ? OPT_TOP_END : sel_i;
      right = sel_i == OPT_PLAY_1P ? OPT_TOP_1P :
              (sel_i == OPT_PLAY_END || sel_i == OPT_PLAY_2P) ? OPT_TOP_END : sel_i;
      left  = sel_i == OPT_TOP_1P ? OPT_PLAY_1P : sel_i == OPT_TOP_END ? OPT_PLAY_END : sel_i;
      next_sel_o = dir_i == DIR_UP ? up : dir_i == DIR_DOWN ? down :
                   dir_i == DIR_LEFT ? left : dir_i == DIR_RIGHT ? right : sel_i;
   end
endmodule

// File: rtl/mainmenu_controller.sv
// mainmenu_controller: main-menu navigation with hold-to-repeat and one-cycle launch pulse
module mainmenu_controller
   import mainmenu_pkg::*;
#(
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 7500000,
   parameter int CNT_W        = 25
) (
   input logic       clk,
   input logic       rst,
   mainmenu_if.slave mm_if
);
   localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);
   state_t           state_q;
   opt_t             sel_q, mode_q, sel_d;
   logic             start_q, phase_q;
   logic [CNT_W-1:0] cnt_q;
   btn_t             prev_q, btn, rise;
   dir_t             held_q, press_dir, step_dir;
   logic             hold_ok, step;
   assign btn = {mm_if.btn_select, mm_if.btn_up, mm_if.btn_down, mm_if.btn_left, mm_if.btn_right};
   assign rise = btn & ~prev_q;
   always_comb begin
      press_dir = rise[BTN_UP] ? DIR_UP : rise[BTN_DOWN] ? DIR_DOWN :
                  rise[BTN_LEFT] ? DIR_LEFT : rise[BTN_RIGHT] ? DIR_RIGHT : DIR_NONE;
      step_dir  = press_dir != DIR_NONE ? press_dir : held_q;
      // repeat only while the held button is the sole button high
      hold_ok   = held_q != DIR_NONE && btn == dir_mask(held_q);
      step      = hold_ok && cnt_q == (phase_q ? RATE_LAST : DLY_LAST);
   end
   mainmenu_nav_lut u_lut (.sel_i(sel_q), .dir_i(step_dir), .next_sel_o(sel_d));
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= OPT_PLAY_1P;
         mode_q  <= OPT_PLAY_1P;
         start_q <= 1'b0;
         cnt_q   <= '0;
         phase_q <= 1'b0;
         held_q  <= DIR_NONE;
         prev_q  <= '0;
      end else begin
         prev_q  <= btn;
         start_q <= 1'b0;
         if (!mm_if.menu_active) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            held_q  <= DIR_NONE;
         end else begin
            case (state_q)
               IDLE:     state_q <= WAIT_REL;
               WAIT_REL: if (btn == '0) state_q <= NAV;
               NAV: begin
                  if (rise[BTN_SEL]) begin
                     state_q <= LAUNCH;
                     start_q <= 1'b1;
                     mode_q  <= sel_q;
                     cnt_q   <= '0;
                     phase_q <= 1'b0;
                     held_q  <= DIR_NONE;
                  end else if (press_dir != DIR_NONE) begin
                     sel_q   <= sel_d;
                     cnt_q   <= '0;
                     phase_q <= 1'b0;
                     held_q  <= press_dir;
                  end else if (hold_ok) begin
                     cnt_q <= step ? '0 : cnt_q + CNT_W'(1);
                     if (step) begin
                        sel_q   <= sel_d;
                        phase_q <= 1'b1;
                     end
                  end else begin
                     cnt_q   <= '0;
                     phase_q <= 1'b0;
                     held_q  <= DIR_NONE;
                  end
               end
               LAUNCH:  state_q <= DONE;
               DONE:    state_q <= DONE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end
   assign mm_if.sel   = sel_q;
   assign mm_if.start = start_q;
   assign mm_if.mode  = mode_q;
endmodule

// File: doc/mainmenu_controller.md
# mainmenu_controller

Sequential controller for the main-menu screen. Turns debounced button levels into the 3-bit selected-option code that the VGA menu renderer reads from metadata[28:26]. Handles two-column grid navigation, hold-to-repeat, and the confirm action. On confirm it issues a one-cycle launch pulse with the latched game mode to the top-level game FSM.

## Interface
- REPEAT_DELAY, 25000000: cycles a held navigation button must stay high before the first auto-repeat step.
- REPEAT_RATE, 7500000: cycles between subsequent auto-repeat steps.
- CNT_W, 25: width of the hold counter; must satisfy 2^CNT_W > max(REPEAT_DELAY, REPEAT_RATE).
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- menu_active  in  1  high while the top level displays the main menu.
- btn_up, btn_down, btn_left, btn_right, btn_select  in  1 each  button levels, already synchronized and debounced.
- sel  out  3  current option code, driven to metadata[28:26].
- start  out  1  one-cycle launch pulse.
- mode  out  3  option code latched at launch; stable until the next launch.

## Operation
- Option codes:
  - 0 = PLAY 1P, 1 = PLAY ENDLESS, 2 = PLAY 2P (left column, rows 0-2).
  - 3 = TOP 1P, 4 = TOP END (right column, rows 0-1).
  - Codes 5-7 never appear on sel.
- Navigation, no wrap; moves off the grid saturate:
  - up: 1→0, 2→1, 4→3; 0 and 3 stay.
  - down: 0→1, 1→2, 3→4; 2 and 4 stay.
  - right: 0→3, 1→4, 2→4; 3 and 4 stay.
  - left: 3→0, 4→1; 0, 1 and 2 stay.
- Press = rising edge of a button level, detected against a registered copy of the previous levels.
- Priority within a cycle: select > up > down > left > right; only one action per cycle.
- States:
  - IDLE: menu_active=0; buttons ignored. Go to WAIT_REL when menu_active rises.
  - WAIT_REL: go to NAV once all five buttons are low, so the button that ended the previous screen is not taken as a press.
  - NAV: apply navigation on presses. A select press goes to LAUNCH.
  - LAUNCH: exactly one cycle. start=1, mode←sel. Then go to DONE.
  - DONE: stay until menu_active=0, then go to IDLE.
- menu_active falling in any state goes to IDLE next cycle; the hold counter clears.
- sel keeps its value across menu exits and re-entries; only reset returns it to 0.
- Auto-repeat, NAV state only:
  - The counter clears on each navigation press and counts while that same button stays high and no other button is high.
  - At count REPEAT_DELAY-1: one repeat step, counter clears, phase switches to rate.
  - Then one step every REPEAT_RATE cycles.
  - The counter and phase clear when the button is released or any second button goes high.
  - Select never repeats.

## Timing
- Reset values: state=IDLE, sel=0, mode=0, start=0, hold counter=0, previous-button register=0.
- Press latency: button rises at edge N; sel shows the new code after edge N+1.
- Select latency: btn_select rises at edge N; start=1 for the cycle after edge N+1, and mode is valid from that same edge.
- First repeat occurs REPEAT_DELAY cycles after the press step; subsequent repeats every REPEAT_RATE cycles.
- Reset asserted mid-hold or mid-LAUNCH: start drops immediately (asynchronous), and no pulse follows reset release.
- Select and a navigation button rising in the same cycle: launch with the pre-move sel.

## Structure
- Shared package mainmenu_pkg holds:
  - option-code constants OPT_PLAY_1P..OPT_TOP_END;
  - state encoding (IDLE, WAIT_REL, NAV, LAUNCH, DONE);
  - direction enum.
- The renderer imports the same option constants.
- One combinational sub-module, mainmenu_nav_lut: inputs (sel, dir), output next_sel, implementing the navigation rules above.

## Test plan
- Reset, raise menu_active with all buttons low, pulse btn_down twice → sel 0→1→2, each change one cycle after the press edge; a third btn_down leaves sel at 2.
- From sel=1, pulse btn_right → sel=4. Then btn_up → 3. Then btn_left → 0.
- REPEAT_DELAY=8, REPEAT_RATE=4: hold btn_down from sel=0 for 20 cycles → sel 1 at press, 2 after 8 cycles, then stays 2; waveform shows repeat strobes at cycles +8, +12, +16.
- Raise menu_active while btn_select is already high → no start. Release, then press select at sel=3 → single start pulse, mode=3, state DONE. Further presses ignored until menu_active falls.
- Press btn_select and btn_up in the same cycle at sel=1 → start=1, mode=1, sel stays 1.
- Assert reset during the LAUNCH cycle → start=0 immediately; after release sel=0, mode=0, state IDLE.
